alu_uart_interface: RTL and testbench

Sequencer that drives the ALU from a byte-serial link. It collects operand A, operand B and the operation code from the UART receiver, presents them to the combinational ALU, and hands the 8-bit result to the UART transmitter. It is the initiator side of the ALU's operand/op/result interface and sits between the UART RX/TX blocks and the ALU in the top level.

---
 rtl/alu_uart_interface.sv | 77 +++++++
 tb/tb_alu_uart_interface.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects A, B, op bytes from UART RX, runs the ALU, sends the result to UART TX.
// Optional inter-byte timeout in GET_B/GET_OP is enabled with `define ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int N_BITS         = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_BITS-1:0]    i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [N_BITS-1:0]    i_alu_result,
  output logic [N_BITS-1:0]    o_alu_data1,
  output logic [N_BITS-1:0]    o_alu_data2,
  output logic [N_BITS_OP-1:0] o_alu_op,
  output logic [N_BITS-1:0]    o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, WAIT_TX} state_t;
  state_t state;
  assign o_busy = (state == EXEC) || (state == WAIT_TX);
`ifdef ALU_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic          tmo;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  // counts idle cycles only while a frame is partially received
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= ((state == GET_B || state == GET_OP) && !i_rx_done && !tmo) ? cnt + 1'b1 : '0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= GET_A;
      o_alu_data1 <= '0;
      o_alu_data2 <= '0;
      o_alu_op    <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        GET_A:
          if (i_rx_done) begin
            o_alu_data1 <= i_rx_data;
            state       <= GET_B;
          end
        GET_B:
          if (i_rx_done) begin
            o_alu_data2 <= i_rx_data;
            state       <= GET_OP;
          end
`ifdef ALU_IF_TIMEOUT_EN
          else if (tmo) state <= GET_A;
`endif
        GET_OP:
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[N_BITS_OP-1:0];
            state    <= EXEC;
          end
`ifdef ALU_IF_TIMEOUT_EN
          else if (tmo) state <= GET_A;
`endif
        EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= WAIT_TX;
        end
        WAIT_TX:
          if (i_tx_done) state <= GET_A;
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface: directed frames through the sequencer with a behavioural ALU attached.
module tb_alu_uart_interface;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_data1, o_alu_data2, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy;
  int         n_vec = 0;
  int         n_bad = 0;
  alu_uart_interface #(.N_BITS(8), .N_BITS_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .o_alu_data1(o_alu_data1),
    .o_alu_data2(o_alu_data2), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  always_comb begin
    i_alu_result = 8'h00;
    case (o_alu_op)
      6'h20: i_alu_result = o_alu_data1 + o_alu_data2;
      6'h22: i_alu_result = o_alu_data1 - o_alu_data2;
      6'h24: i_alu_result = o_alu_data1 & o_alu_data2;
      6'h25: i_alu_result = o_alu_data1 | o_alu_data2;
      6'h26: i_alu_result = o_alu_data1 ^ o_alu_data2;
      6'h27: i_alu_result = ~(o_alu_data1 | o_alu_data2);
      6'h02: i_alu_result = o_alu_data1 >> o_alu_data2;
      6'h03: i_alu_result = $signed(o_alu_data1) >>> o_alu_data2;
      default: i_alu_result = 8'h00;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask
  task automatic tx_ack();
    @(negedge i_clk);
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask
  // leaves the DUT in WAIT_TX, one cycle after the tx_start pulse
  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [5:0] exp_op, input logic [7:0] exp_res);
    send(a);
    send(b);
    send(op);
    chk({tag, " op"}, 32'(o_alu_op), 32'(exp_op));
    chk({tag, " busy exec"}, 32'(o_busy), 32'd1);
    chk({tag, " start early"}, 32'(o_tx_start), 32'd0);
    @(negedge i_clk);
    chk({tag, " start"}, 32'(o_tx_start), 32'd1);
    chk({tag, " result"}, 32'(o_tx_data), 32'(exp_res));
    @(negedge i_clk);
    chk({tag, " start once"}, 32'(o_tx_start), 32'd0);
    chk({tag, " result held"}, 32'(o_tx_data), 32'(exp_res));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst data1", 32'(o_alu_data1), 0);
    chk("rst data2", 32'(o_alu_data2), 0);
    chk("rst op", 32'(o_alu_op), 0);
    chk("rst tx_data", 32'(o_tx_data), 0);
    chk("rst start", 32'(o_tx_start), 0);
    chk("rst busy", 32'(o_busy), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    tx_ack();
    chk("stray tx_done busy", 32'(o_busy), 0);
    frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
    tx_ack();
    chk("add idle", 32'(o_busy), 0);
    frame("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
    send(8'h55);
    chk("drop in wait", 32'(o_alu_data1), 32'h03);
    tx_ack();
    frame("nor", 8'hF0, 8'h0F, 8'hE7, 6'h27, 8'h00);
    @(negedge i_clk);
    i_rx_data = 8'h11;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    chk("simul busy", 32'(o_busy), 0);
    chk("simul drop", 32'(o_alu_data1), 32'hF0);
    frame("add2", 8'h01, 8'h02, 8'h20, 6'h20, 8'h03);
    tx_ack();
    send(8'hAA);
    send(8'hBB);
    chk("pre-rst data2", 32'(o_alu_data2), 32'hBB);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async data1", 32'(o_alu_data1), 0);
    chk("async data2", 32'(o_alu_data2), 0);
    chk("async op", 32'(o_alu_op), 0);
    chk("async tx_data", 32'(o_tx_data), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    frame("srl", 8'h04, 8'h01, 8'h02, 6'h02, 8'h02);
    tx_ack();
    frame("undef", 8'h12, 8'h34, 8'h3F, 6'h3F, 8'h00);
    tx_ack();
    chk("undef idle", 32'(o_busy), 0);
    send(8'h07);
    repeat (20) @(negedge i_clk);
    send(8'h01);
    send(8'h02);
`ifdef ALU_IF_TIMEOUT_EN
    send(8'h20);
    chk("tmo data1", 32'(o_alu_data1), 32'h01);
    chk("tmo data2", 32'(o_alu_data2), 32'h02);
    chk("tmo op", 32'(o_alu_op), 32'h20);
`else
    chk("gap data1", 32'(o_alu_data1), 32'h07);
    chk("gap data2", 32'(o_alu_data2), 32'h01);
    chk("gap op", 32'(o_alu_op), 32'h02);
`endif
    chk("gap busy", 32'(o_busy), 1);
    @(negedge i_clk);
    chk("gap start", 32'(o_tx_start), 1);
    chk("gap result", 32'(o_tx_data), 32'h03);
`ifndef ALU_IF_TIMEOUT_EN
    send(8'h20);
`endif
    tx_ack();
    chk("gap idle", 32'(o_busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
